// File: rtl/nr_sel_arbiter.sv
// Registered round-robin arbiter feeding the 2-bit-select source mux.
// Optional macro NR_SEL_PARITY_EN adds the registered out_par output.
module nr_sel_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] dat,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] out_sel,
  output logic       out_dat,
  output logic       idle
`ifdef NR_SEL_PARITY_EN
  ,
  output logic       out_par
`endif
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);
  localparam logic [1:0] SEL_IDLE = 2'b11;

  state_t     state;
  logic [1:0] owner;
  logic [3:0] burst_cnt;

  logic       load;
  logic       keep;
  logic       rot_ok;
  logic       solo;
  logic       go;
  logic [1:0] c1;
  logic [1:0] c2;
  logic [1:0] g_own;
  logic       g_dat;

  // Candidates in rotation order after the current owner.
  always_comb begin
    c1     = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    c2     = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    load   = !out_valid || out_ready;
    keep   = (state == GRANT) && req[owner]
             && (burst_cnt < BMAX);
    rot_ok = req[c1] || req[c2];
    solo   = req[owner];
    go     = keep || rot_ok || solo;
    g_own  = owner;
    if (!keep && rot_ok) begin
      g_own = req[c1] ? c1 : c2;
    end
    g_dat  = dat[g_own];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd2;
      burst_cnt <= 4'd0;
      out_valid <= 1'b0;
      out_sel   <= SEL_IDLE;
      out_dat   <= 1'b0;
      idle      <= 1'b1;
`ifdef NR_SEL_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (load) begin
      if (go) begin
        state     <= GRANT;
        owner     <= g_own;
        burst_cnt <= keep ? burst_cnt + 4'd1 : 4'd1;
        out_valid <= 1'b1;
        out_sel   <= g_own;
        out_dat   <= g_dat;
        idle      <= 1'b0;
`ifdef NR_SEL_PARITY_EN
        out_par   <= ^{g_own, g_dat};
`endif
      end else begin
        // Owner is kept so the next search resumes fairly.
        state     <= IDLE;
        burst_cnt <= 4'd0;
        out_valid <= 1'b0;
        out_sel   <= SEL_IDLE;
        out_dat   <= 1'b0;
        idle      <= 1'b1;
`ifdef NR_SEL_PARITY_EN
        out_par   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nr_sel_arbiter.sv
// Scoreboard bench for nr_sel_arbiter: reference model pushes expected
// outputs each edge, a negedge monitor pops and compares.
module tb_nr_sel_arbiter;

  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b111;
  logic [2:0] dat = 3'b000;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [1:0] out_sel;
  logic       out_dat;
  logic       idle;
`ifdef NR_SEL_PARITY_EN
  logic       out_par;
`endif

  nr_sel_arbiter #(.BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dat       (dat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_dat   (out_dat),
    .idle      (idle)
`ifdef NR_SEL_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [1:0] s;
    logic       d;
    logic       i;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   run     = 1'b1;

  // Reference model state (plain integers).
  int m_owner = 2;
  int m_cnt   = 0;
  int m_valid = 0;
  int m_sel   = 3;
  int m_dat   = 0;

  always @(posedge clk) begin
    exp_t e;
    int   found;
    if (run) begin
      if (rst) begin
        m_owner = 2; m_cnt = 0; m_valid = 0;
        m_sel = 3; m_dat = 0;
      end else if (m_valid == 0 || out_ready) begin
        if (m_valid != 0 && req[m_owner] && m_cnt < BM) begin
          m_cnt = m_cnt + 1;
        end else begin
          found = -1;
          for (int k = 1; k <= 2; k++) begin
            if (found < 0 && req[(m_owner + k) % 3]) found = (m_owner + k) % 3;
          end
          if (found >= 0) begin
            m_owner = found; m_cnt = 1;
          end else if (req[m_owner]) begin
            m_cnt = 1;
          end else begin
            m_cnt = 0; m_valid = 0; m_sel = 3; m_dat = 0;
          end
          if (found >= 0 || req[m_owner]) m_valid = 1;
        end
        if (m_valid != 0) begin
          m_sel = m_owner;
          m_dat = dat[m_owner];
        end
      end
      e.v = (m_valid != 0);
      e.s = 2'(m_sel);
      e.d = (m_dat != 0);
      e.i = (m_valid == 0);
      e.p = ^{e.s, e.d};
      if (e.v == 1'b0) e.p = 1'b0;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic p_act;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
`ifdef NR_SEL_PARITY_EN
      p_act = out_par;
`else
      p_act = e.p;
`endif
      if (out_valid !== e.v || out_sel !== e.s || out_dat !== e.d
          || idle !== e.i || p_act !== e.p) begin
        errors++;
        $display("FAIL vec%0d t=%0t got v=%b sel=%b dat=%b idle=%b par=%b exp v=%b sel=%b dat=%b idle=%b par=%b",
                 vectors, $time, out_valid, out_sel, out_dat, idle, p_act,
                 e.v, e.s, e.d, e.i, e.p);
      end
    end
  end

  task automatic step(input logic r, input logic [2:0] rq,
                      input logic [2:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; req = rq; dat = d; out_ready = rdy;
  endtask

  initial begin
    step(1'b1, 3'b111, 3'b000, 1'b1);
    step(1'b1, 3'b111, 3'b000, 1'b1);
    // Full contention: bursts of BM per source in rotation.
    for (int i = 0; i < 14; i++) step(1'b0, 3'b111, 3'(i), 1'b1);
    // Lone requester with toggling data.
    for (int i = 0; i < 6; i++) step(1'b0, 3'b010, {1'b0, i[0], 1'b0}, 1'b1);
    // Stall while inputs change.
    step(1'b0, 3'b001, 3'b001, 1'b1);
    step(1'b0, 3'b100, 3'b110, 1'b0);
    step(1'b0, 3'b100, 3'b001, 1'b0);
    step(1'b0, 3'b100, 3'b110, 1'b0);
    step(1'b0, 3'b100, 3'b100, 1'b1);
    step(1'b0, 3'b100, 3'b000, 1'b1);
    // Drop to idle, then resume from owner b.
    step(1'b0, 3'b000, 3'b111, 1'b1);
    step(1'b0, 3'b000, 3'b111, 1'b1);
    step(1'b0, 3'b010, 3'b010, 1'b1);
    step(1'b0, 3'b000, 3'b010, 1'b1);
    step(1'b0, 3'b111, 3'b101, 1'b1);
    step(1'b0, 3'b111, 3'b010, 1'b1);
    // Reset during a stalled burst.
    step(1'b0, 3'b111, 3'b010, 1'b0);
    step(1'b0, 3'b111, 3'b101, 1'b0);
    step(1'b1, 3'b111, 3'b101, 1'b0);
    step(1'b0, 3'b010, 3'b000, 1'b1);
    step(1'b0, 3'b010, 3'b000, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), 3'($urandom),
           3'($urandom), ($urandom_range(0, 9) < 7));
    end
    step(1'b0, 3'b000, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
